// File: rtl/i2s_tdm_serdes.sv
// I2S / left-justified / TDM serdes for a clock-master codec: synchronises bclk/lrclk,
// deserialises one ADC frame per frame edge and serialises one DAC frame per frame.
module i2s_tdm_serdes #(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int MODE       = 0,
  parameter int UNDER_ZERO = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sdata_i,
  output logic                         sdata_o,
  input  logic                         bclk,
  input  logic                         lrclk,
  input  logic [CHANNELS*SAMPLE_W-1:0] dac_sample_data,
  input  logic                         dac_sample_valid,
  output logic                         dac_sample_ready,
  output logic [CHANNELS*SAMPLE_W-1:0] adc_sample_data,
  output logic                         adc_sample_valid,
  input  logic                         adc_sample_ready,
  input  logic                         clear_status,
  output logic                         overrun,
  output logic                         underrun,
  output logic                         frame_err
);

  localparam int NB    = CHANNELS * SAMPLE_W;
  localparam int FRAME = CHANNELS * SLOT_W;
  localparam int CW    = $clog2(FRAME + 1);
  localparam int IW    = $clog2(NB);
  localparam int D     = (MODE == 0) ? 1 : 0;
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  state_t        state_q, state_d;
  logic [2:0]    bclk_sr, lrclk_sr;
  logic [1:0]    sd_sr;
  logic          bclk_rise, bclk_fall, lr_rise, lr_fall, frame_edge, edge_run, sd;
  logic [CW-1:0] bit_cnt, tx_cnt;
  logic [IW:0]   rx_map, tx_map;
  logic [NB-1:0] rx_reg, tx_reg, tx_next, hold;
  logic          full, dac_accept;

  // Frame-bit position -> {valid, index into the ch0-in-MSBs frame vector}.
  function automatic logic [IW:0] bit_map(input int c);
    int p, s, k;
    bit_map = '0;
    p = c - D;
    if (p >= 0) begin
      s = p / SLOT_W;
      k = p % SLOT_W;
      if (s < CHANNELS && k < SAMPLE_W)
        bit_map = {1'b1, IW'((CHANNELS - 1 - s) * SAMPLE_W + SAMPLE_W - 1 - k)};
    end
  endfunction

  assign bclk_rise  = bclk_sr[1] & ~bclk_sr[2];
  assign bclk_fall  = ~bclk_sr[1] & bclk_sr[2];
  assign lr_rise    = lrclk_sr[1] & ~lrclk_sr[2];
  assign lr_fall    = ~lrclk_sr[1] & lrclk_sr[2];
  assign frame_edge = (MODE == 0) ? lr_fall : lr_rise;
  assign edge_run   = frame_edge && (state_q == RUN);
  assign sd         = sd_sr[1];

  assign dac_sample_ready = !full;
  assign dac_accept       = dac_sample_valid && !full;

  // A fall coinciding with the frame edge drives the first bit of the new frame.
  assign tx_cnt = frame_edge ? '0 : bit_cnt;
  assign rx_map = bit_map(int'(bit_cnt));
  assign tx_map = bit_map(int'(tx_cnt));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_edge) state_d = SYNC;
      SYNC:    if (frame_edge) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_next = tx_reg;
    if (edge_run) begin
      if (full)                 tx_next = hold;
      else if (dac_accept)      tx_next = dac_sample_data;
      else if (UNDER_ZERO != 0) tx_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bclk_sr  <= '0;
      lrclk_sr <= '0;
      sd_sr    <= '0;
    end else begin
      state_q  <= state_d;
      bclk_sr  <= {bclk_sr[1:0], bclk};
      lrclk_sr <= {lrclk_sr[1:0], lrclk};
      sd_sr    <= {sd_sr[0], sdata_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt          <= '0;
      rx_reg           <= '0;
      tx_reg           <= '0;
      hold             <= '0;
      full             <= 1'b0;
      sdata_o          <= 1'b0;
      adc_sample_data  <= '0;
      adc_sample_valid <= 1'b0;
      overrun          <= 1'b0;
      underrun         <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      if (frame_edge)                          bit_cnt <= '0;
      else if (bclk_rise && bit_cnt != FRAME_C) bit_cnt <= bit_cnt + 1'b1;

      if (bclk_rise && rx_map[IW]) rx_reg[rx_map[IW-1:0]] <= sd;

      tx_reg <= tx_next;
      if (bclk_fall) sdata_o <= tx_map[IW] ? tx_next[tx_map[IW-1:0]] : 1'b0;

      if (dac_accept) hold <= dac_sample_data;
      if (edge_run)        full <= 1'b0;
      else if (dac_accept) full <= 1'b1;

      if (edge_run) begin
        adc_sample_data  <= rx_reg;
        adc_sample_valid <= 1'b1;
      end else if (adc_sample_valid && adc_sample_ready) begin
        adc_sample_valid <= 1'b0;
      end

      if (edge_run && adc_sample_valid && !adc_sample_ready) overrun <= 1'b1;
      else if (clear_status)                                 overrun <= 1'b0;
      if (edge_run && !full && !dac_accept) underrun <= 1'b1;
      else if (clear_status)                underrun <= 1'b0;
      if (edge_run && bit_cnt != FRAME_C) frame_err <= 1'b1;
      else if (clear_status)              frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_tdm_serdes.sv
// Directed bench: stereo I2S instance (UNDER_ZERO=1) and 4-slot TDM LJ instance (UNDER_ZERO=0)
// driven by a bit-level codec model that also decodes the DAC stream.
module tb_i2s_tdm_serdes;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, bclk0, lrclk0, sd0_i, sd0_o, dac0_valid, dac0_ready, adc0_valid, adc0_ready;
  logic        clr0, ovr0, und0, fe0;
  logic [47:0] dac0_data, adc0_data;
  logic        rst1, bclk1, lrclk1, sd1_i, sd1_o, dac1_valid, dac1_ready, adc1_valid, adc1_ready;
  logic        clr1, ovr1, und1, fe1;
  logic [95:0] dac1_data, adc1_data;

  int checks = 0;
  int errors = 0;
  int beats0 = 0;
  int beats1 = 0;
  int unused1;
  logic [47:0] last0;
  logic [95:0] last1;
  logic [23:0] tx_slots[4];
  logic [23:0] rx_slots[4];

  localparam logic [95:0] P1 = {24'hA5A5A5, 24'h5A5A5A, 24'hC00003, 24'h000001};
  localparam logic [95:0] P2 = {24'h123456, 24'h789ABC, 24'hDEF012, 24'h800001};

  i2s_tdm_serdes #(.SAMPLE_W(24), .SLOT_W(32), .CHANNELS(2), .MODE(0), .UNDER_ZERO(1)) dut0 (
    .clk(clk), .reset(rst0), .sdata_i(sd0_i), .sdata_o(sd0_o), .bclk(bclk0), .lrclk(lrclk0),
    .dac_sample_data(dac0_data), .dac_sample_valid(dac0_valid), .dac_sample_ready(dac0_ready),
    .adc_sample_data(adc0_data), .adc_sample_valid(adc0_valid), .adc_sample_ready(adc0_ready),
    .clear_status(clr0), .overrun(ovr0), .underrun(und0), .frame_err(fe0));

  i2s_tdm_serdes #(.SAMPLE_W(24), .SLOT_W(32), .CHANNELS(4), .MODE(1), .UNDER_ZERO(0)) dut1 (
    .clk(clk), .reset(rst1), .sdata_i(sd1_i), .sdata_o(sd1_o), .bclk(bclk1), .lrclk(lrclk1),
    .dac_sample_data(dac1_data), .dac_sample_valid(dac1_valid), .dac_sample_ready(dac1_ready),
    .adc_sample_data(adc1_data), .adc_sample_valid(adc1_valid), .adc_sample_ready(adc1_ready),
    .clear_status(clr1), .overrun(ovr1), .underrun(und1), .frame_err(fe1));

  // Beat monitors stand in for the downstream stream consumer.
  always @(posedge clk) begin
    if (adc0_valid && adc0_ready) begin beats0 <= beats0 + 1; last0 <= adc0_data; end
    if (adc1_valid && adc1_ready) begin beats1 <= beats1 + 1; last1 <= adc1_data; end
  end

  // One codec frame of nb bclk periods: drive on the fall, sample sdata_o on the rise.
  task automatic run_frame(input int which, input int nb);
    int ch, d, p, s, k;
    logic ok, b, o;
    ch = (which != 0) ? 4 : 2;
    d  = (which != 0) ? 0 : 1;
    unused1 = 0;
    for (int i = 0; i < 4; i++) rx_slots[i] = '0;
    for (int j = 0; j < nb; j++) begin
      p = j - d; s = 0; k = 0; ok = 1'b0;
      if (p >= 0) begin
        s = p / 32; k = p % 32;
        ok = (s < ch) && (k < 24);
      end
      b = ok ? tx_slots[s][23-k] : 1'b0;
      if (which == 0) begin bclk0 = 1'b0; lrclk0 = (j >= 32); sd0_i = b; end
      else            begin bclk1 = 1'b0; lrclk1 = (j == 0);  sd1_i = b; end
      repeat (5) @(negedge clk);
      if (which == 0) begin bclk0 = 1'b1; o = sd0_o; end
      else            begin bclk1 = 1'b1; o = sd1_o; end
      if (ok) rx_slots[s][23-k] = o;
      else if (o) unused1++;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst0 = 1'b1; rst1 = 1'b1;
    bclk0 = 1'b1; lrclk0 = 1'b1; sd0_i = 1'b0; clr0 = 1'b0; adc0_ready = 1'b1;
    bclk1 = 1'b1; lrclk1 = 1'b0; sd1_i = 1'b0; clr1 = 1'b0; adc1_ready = 1'b1;
    dac0_data = 48'h800001_7FFFFE; dac0_valid = 1'b1;
    dac1_data = P1; dac1_valid = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (sd0_o !== 1'b0) begin errors++; $display("FAIL rst_sdata0 got %b want 0", sd0_o); end
    checks++; if (adc0_valid !== 1'b0) begin errors++; $display("FAIL rst_valid0 got %b want 0", adc0_valid); end
    checks++; if (dac0_ready !== 1'b1) begin errors++; $display("FAIL rst_ready0 got %b want 1", dac0_ready); end
    checks++; if ({ovr0, und0, fe0} !== 3'b000) begin errors++; $display("FAIL rst_flags0 got %b want 000", {ovr0, und0, fe0}); end
    checks++; if (sd1_o !== 1'b0) begin errors++; $display("FAIL rst_sdata1 got %b want 0", sd1_o); end
    checks++; if (adc1_valid !== 1'b0) begin errors++; $display("FAIL rst_valid1 got %b want 0", adc1_valid); end
    checks++; if (dac1_ready !== 1'b1) begin errors++; $display("FAIL rst_ready1 got %b want 1", dac1_ready); end
    checks++; if ({ovr1, und1, fe1} !== 3'b000) begin errors++; $display("FAIL rst_flags1 got %b want 000", {ovr1, und1, fe1}); end
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (3) @(negedge clk);
    dac1_data = P2; // P1 already sits in the holding register
  endtask

  task automatic test_i2s_stereo;
    tx_slots[0] = 24'hABCDEF; tx_slots[1] = 24'h123456; tx_slots[2] = '0; tx_slots[3] = '0;
    run_frame(0, 64);
    run_frame(0, 64);
    checks++; if (beats0 !== 0) begin errors++; $display("FAIL i2s_no_partial_beat got %0d want 0", beats0); end
    run_frame(0, 64);
    checks++; if (beats0 !== 1) begin errors++; $display("FAIL i2s_beat_count got %0d want 1", beats0); end
    checks++; if (last0 !== 48'hABCDEF123456) begin errors++; $display("FAIL i2s_adc_data got %h want abcdef123456", last0); end
    checks++; if (rx_slots[0] !== 24'h800001) begin errors++; $display("FAIL i2s_dac_left got %h want 800001", rx_slots[0]); end
    checks++; if (rx_slots[1] !== 24'h7FFFFE) begin errors++; $display("FAIL i2s_dac_right got %h want 7ffffe", rx_slots[1]); end
    checks++; if (unused1 !== 0) begin errors++; $display("FAIL i2s_unused_bits got %0d want 0", unused1); end
    checks++; if (und0 !== 1'b0) begin errors++; $display("FAIL i2s_no_underrun got %b want 0", und0); end
  endtask

  task automatic test_overrun;
    adc0_ready = 1'b0;
    tx_slots[0] = 24'h0F0F0F; tx_slots[1] = 24'hF0F0F0;
    run_frame(0, 64);
    tx_slots[0] = 24'h654321; tx_slots[1] = 24'hFEDCBA;
    run_frame(0, 64);
    checks++; if (adc0_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held got %b want 1", adc0_valid); end
    checks++; if (ovr0 !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", ovr0); end
    checks++; if (adc0_data !== 48'h0F0F0F_F0F0F0) begin errors++; $display("FAIL ovr_latest_data got %h want 0f0f0ff0f0f0", adc0_data); end
    clr0 = 1'b1; @(negedge clk); clr0 = 1'b0; @(negedge clk);
    checks++; if (ovr0 !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", ovr0); end
    adc0_ready = 1'b1; repeat (2) @(negedge clk);
    checks++; if (last0 !== 48'h0F0F0F_F0F0F0) begin errors++; $display("FAIL ovr_drain got %h want 0f0f0ff0f0f0", last0); end
  endtask

  task automatic test_underrun;
    dac0_valid = 1'b0;
    run_frame(0, 64);
    checks++; if (und0 !== 1'b0) begin errors++; $display("FAIL und_held_beat got %b want 0", und0); end
    checks++; if ({rx_slots[0], rx_slots[1]} !== 48'h800001_7FFFFE) begin errors++; $display("FAIL und_last_beat got %h want 8000017ffffe", {rx_slots[0], rx_slots[1]}); end
    run_frame(0, 64);
    checks++; if ({rx_slots[0], rx_slots[1]} !== 48'h0) begin errors++; $display("FAIL und_zero_slots got %h want 0", {rx_slots[0], rx_slots[1]}); end
    checks++; if (und0 !== 1'b1) begin errors++; $display("FAIL und_set got %b want 1", und0); end
    checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL fe_clean got %b want 0", fe0); end
  endtask

  task automatic test_frame_err;
    run_frame(0, 40);
    tx_slots[0] = 24'h13579B; tx_slots[1] = 24'h2468AC;
    run_frame(0, 64);
    checks++; if (fe0 !== 1'b1) begin errors++; $display("FAIL fe_set got %b want 1", fe0); end
    run_frame(0, 64);
    checks++; if (last0 !== 48'h13579B_2468AC) begin errors++; $display("FAIL fe_realign got %h want 13579b2468ac", last0); end
  endtask

  task automatic test_reset_midframe;
    int b0;
    dac0_valid = 1'b1;
    run_frame(0, 20);
    rst0 = 1'b1; repeat (3) @(negedge clk);
    checks++; if (sd0_o !== 1'b0) begin errors++; $display("FAIL mid_rst_sdata got %b want 0", sd0_o); end
    checks++; if (adc0_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", adc0_valid); end
    checks++; if (dac0_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", dac0_ready); end
    checks++; if ({ovr0, und0, fe0} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags got %b want 000", {ovr0, und0, fe0}); end
    rst0 = 1'b0;
    b0 = beats0;
    tx_slots[0] = 24'h0C0FFE; tx_slots[1] = 24'hBEEF01;
    run_frame(0, 64); run_frame(0, 64); run_frame(0, 64);
    checks++; if (beats0 !== b0) begin errors++; $display("FAIL mid_rst_resync got %0d want %0d", beats0, b0); end
    run_frame(0, 64);
    checks++; if (beats0 !== b0 + 1) begin errors++; $display("FAIL mid_rst_beat got %0d want %0d", beats0, b0 + 1); end
    checks++; if (last0 !== 48'h0C0FFE_BEEF01) begin errors++; $display("FAIL mid_rst_data got %h want 0c0ffebeef01", last0); end
  endtask

  task automatic test_tdm;
    tx_slots[0] = 24'h111111; tx_slots[1] = 24'h222222; tx_slots[2] = 24'h333333; tx_slots[3] = 24'h444444;
    run_frame(1, 128);
    run_frame(1, 128);
    checks++; if (beats1 !== 0) begin errors++; $display("FAIL tdm_no_partial_beat got %0d want 0", beats1); end
    run_frame(1, 128);
    dac1_valid = 1'b0;
    checks++; if (last1 !== 96'h111111_222222_333333_444444) begin errors++; $display("FAIL tdm_adc_data got %h want 111111222222333333444444", last1); end
    checks++; if ({rx_slots[0], rx_slots[1], rx_slots[2], rx_slots[3]} !== P1) begin errors++; $display("FAIL tdm_dac_p1 got %h want %h", {rx_slots[0], rx_slots[1], rx_slots[2], rx_slots[3]}, P1); end
    checks++; if (unused1 !== 0) begin errors++; $display("FAIL tdm_unused_bits got %0d want 0", unused1); end
    run_frame(1, 128);
    checks++; if ({rx_slots[0], rx_slots[1], rx_slots[2], rx_slots[3]} !== P2) begin errors++; $display("FAIL tdm_dac_p2 got %h want %h", {rx_slots[0], rx_slots[1], rx_slots[2], rx_slots[3]}, P2); end
    checks++; if (und1 !== 1'b0) begin errors++; $display("FAIL tdm_no_underrun got %b want 0", und1); end
    run_frame(1, 128);
    checks++; if ({rx_slots[0], rx_slots[1], rx_slots[2], rx_slots[3]} !== P2) begin errors++; $display("FAIL tdm_repeat got %h want %h", {rx_slots[0], rx_slots[1], rx_slots[2], rx_slots[3]}, P2); end
    checks++; if (und1 !== 1'b1) begin errors++; $display("FAIL tdm_underrun got %b want 1", und1); end
  endtask

  initial begin
    test_reset();
    test_i2s_stereo();
    test_overrun();
    test_underrun();
    test_frame_err();
    test_reset_midframe();
    test_tdm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
